// File: rtl/rename_pkg.sv
// Shared rename-side definitions: physical tag sizing, the reset mapping
// boundary and the reclaim FSM state encoding.
package rename_pkg;

    localparam int NUM_PHYS  = 128;
    localparam int ARCH_REGS = 32;
    localparam int TAG_W     = $clog2(NUM_PHYS) + 1;

    typedef logic [TAG_W-1:0] phys_tag_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tag_pend_queue.sv
// Two-in / one-out circular buffer of freed physical tags. The owner guarantees
// it never pushes past DEPTH entries and never pops when empty.
module tag_pend_queue
    import rename_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int TAG_W = rename_pkg::TAG_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_push,
    input  logic [TAG_W-1:0] i_tag_0,
    input  logic [TAG_W-1:0] i_tag_1,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [TAG_W-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_ptr_1;
    logic [CNT_W-1:0] w_n_in;

    // Slot 1 lands right behind slot 0 when both are pushed, else in slot 0's place.
    assign w_wr_ptr_1 = r_wr_ptr + PTR_W'(i_push[0]);
    assign w_n_in     = CNT_W'(i_push[0]) + CNT_W'(i_push[1]);

    always_ff @(posedge clk) begin
        if (i_push[0]) r_mem[r_wr_ptr]   <= i_tag_0;
        if (i_push[1]) r_mem[w_wr_ptr_1] <= i_tag_1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_in);
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= r_count + w_n_in - CNT_W'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/phys_tag_reclaim.sv
// Write-side companion of the physical free list: seeds unmapped tags after
// reset, then buffers retired tags and streams them into tag_fifo under credit.
module phys_tag_reclaim
    import rename_pkg::*;
#(
    parameter  int NUM_PHYS   = rename_pkg::NUM_PHYS,
    parameter  int ARCH_REGS  = rename_pkg::ARCH_REGS,
    parameter  int PEND_DEPTH = 8,
    localparam int TAG_W      = $clog2(NUM_PHYS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_retire_valid,
    input  logic [TAG_W-1:0] i_retire_tag_0,
    input  logic [TAG_W-1:0] i_retire_tag_1,
    output logic             o_retire_ready,
    input  logic [TAG_W-1:0] i_freespace,
    output logic             o_write_tag,
    output logic [TAG_W-1:0] o_write_tag_source,
    output logic             o_init_done,
    output logic             o_overflow_err
);

    localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

    state_t           r_state;
    logic [TAG_W-1:0] r_seed;
    logic             r_write_tag;
    logic [TAG_W-1:0] r_write_src;
    logic             r_init_done;
    logic             r_overflow;
    logic             r_retire_ready;

    state_t           w_state_next;
    logic [TAG_W-1:0] w_seed_next;
    logic             w_write_next;
    logic [TAG_W-1:0] w_src_next;
    logic             w_init_done_next;
    logic             w_overflow_next;
    logic             w_ready_next;

    logic             w_credit;
    logic [1:0]       w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic [TAG_W-1:0] w_head;

    // Credit discounts a write issued last edge that tag_fifo has not yet reflected.
    assign w_credit     = i_freespace > TAG_W'(r_write_tag);
    assign w_push       = i_retire_valid & {2{r_retire_ready}};
    assign w_pop        = (r_state == RUN) && (w_count != '0) && w_credit;
    assign w_count_next = w_count + CNT_W'(w_push[0]) + CNT_W'(w_push[1]) - CNT_W'(w_pop);

    tag_pend_queue #(
        .DEPTH (PEND_DEPTH),
        .TAG_W (TAG_W)
    ) u_pend_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_tag_0 (i_retire_tag_0),
        .i_tag_1 (i_retire_tag_1),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_comb begin
        w_state_next     = r_state;
        w_seed_next      = r_seed;
        w_write_next     = 1'b0;
        w_src_next       = r_write_src;
        w_init_done_next = r_init_done;
        w_overflow_next  = r_overflow | ((|i_retire_valid) & ~r_retire_ready);
        // Ready is withheld for the edge that leaves INIT so it rises one cycle after init_done.
        w_ready_next     = (r_state == RUN) && (w_count_next <= CNT_W'(PEND_DEPTH - 2));

        case (r_state)
            INIT: begin
                if (w_credit) begin
                    w_write_next = 1'b1;
                    w_src_next   = r_seed;
                    w_seed_next  = r_seed + TAG_W'(1);
                    if (r_seed == TAG_W'(NUM_PHYS - 1)) begin
                        w_state_next     = RUN;
                        w_init_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_pop) begin
                    w_write_next = 1'b1;
                    w_src_next   = w_head;
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= INIT;
            r_seed         <= TAG_W'(ARCH_REGS);
            r_write_tag    <= 1'b0;
            r_write_src    <= '0;
            r_init_done    <= 1'b0;
            r_overflow     <= 1'b0;
            r_retire_ready <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_seed         <= w_seed_next;
            r_write_tag    <= w_write_next;
            r_write_src    <= w_src_next;
            r_init_done    <= w_init_done_next;
            r_overflow     <= w_overflow_next;
            r_retire_ready <= w_ready_next;
        end
    end

    assign o_retire_ready     = r_retire_ready;
    assign o_write_tag        = r_write_tag;
    assign o_write_tag_source = r_write_src;
    assign o_init_done        = r_init_done;
    assign o_overflow_err     = r_overflow;

endmodule
